conveyor_drain: RTL and testbench
=================================

CONVEYOR_DRAIN -- requirements
Module: conveyor_drain

Interface
REQ-001 SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 conveyor_stamp_flat  in  24  eight 3-bit stamps; lane i (registers a-h) is at bits [3i+2:3i].
REQ-005 conveyor_stamp_in  in  8  stamp-valid per lane.
REQ-006 conveyor_take_flat  in  40  eight 5-bit take locations; lane i is at bits [5i+4:5i].
REQ-007 conveyor_take_in  in  8  take-valid per lane.
REQ-008 flush  in  1  synchronous discard of all pending and in-flight work.
REQ-009 wb_valid  out  1  writeback request valid (registered).
REQ-010 wb_ready  in  1  writeback consumer accepts when wb_valid and wb_ready are both high.
REQ-011 wb_reg  out  3  register index of the request.
REQ-012 wb_take  out  5  take location of the request.
REQ-013 wb_stamp  out  3  stamp latched for that register.
REQ-014 busy  out  8  per-register flag, set while that register is pending or in flight.
REQ-015 drop_pulse  out  8  one-cycle flag per lane: a pending, unissued take was overwritten.

Function
REQ-016 SHALL hold, per register i: stamp_q[i] (3b), take_q[i] (5b), pend[i] (1b).
REQ-017 Stamp capture: if conveyor_stamp_in[i] at an edge, stamp_q[i] SHALL load lane i; stamp does not set pend.
REQ-018 Take capture: if conveyor_take_in[i] at an edge, take_q[i] SHALL load lane i and pend[i] SHALL set.
REQ-019 Take overwrite: a take arriving while pend[i]=1 and i is not being issued that edge SHALL overwrite take_q[i]; drop_pulse[i]=1 the next cycle.
REQ-020 Output stage SHALL be "empty" when wb_valid=0, and "free" when empty or (wb_valid and wb_ready).
REQ-021 When the output stage is free and any pend=1, it SHALL load in one edge: wb_reg=winner, wb_take=take_q[winner], wb_stamp=stamp_q[winner], wb_valid=1; pend[winner] clears.
REQ-022 A take arriving for the winner on the same edge it loads SHALL re-set pend[winner] with the new value, with no drop.
REQ-023 Arbitration SHALL be round-robin across 8 lanes, starting search at ptr; after a grant, ptr = winner+1 mod 8 (7 wraps to 0).
REQ-024 While wb_valid=1 and wb_ready=0, all wb_* payload SHALL stay stable.
REQ-025 If free and no pend, wb_valid SHALL drop to 0 after an accepting edge.
REQ-026 Throughput: one request per cycle under continuous wb_ready. Latency: take presented in cycle N yields wb_valid in cycle N+2 (empty stage, lane wins).
REQ-027 busy[i] = pend[i] | (wb_valid & wb_reg==i), combinational from registered state.
REQ-028 flush SHALL, at the edge, clear pend, wb_valid and drop_pulse, and SHALL ignore same-edge take inputs; it SHALL still latch same-edge stamp inputs; ptr is kept.
REQ-029 Stamps not yet followed by a take SHALL persist indefinitely (no timeout).

Reset
REQ-030 On rst: pend=0, stamp_q=0, take_q=0, ptr=0, wb_valid=0, wb_reg=0, wb_take=0, wb_stamp=0, drop_pulse=0.
REQ-031 rst SHALL dominate flush and all inputs; rst mid-transfer discards the in-flight request without handshake.

Structure
REQ-032 Shared package SHALL hold NUM_REGS=8, STAMP_W=3, TAKE_W=5, and lane slice helpers, shared with the pool merger.
REQ-033 Round-robin selection SHALL be one sub-module rr_arbiter8: inputs req[8] and ptr[3]; outputs gnt_valid and gnt_idx[3].

Verification
REQ-034 Reset, then stamp lane2=5 and take lane2=17 in cycle 0, wb_ready=1 -> cycle 2: wb_valid=1, reg=2, take=17, stamp=5; cycle 3: wb_valid=0, busy=0.
REQ-035 Takes on lanes 0, 3 and 7 in one cycle, ptr=0, wb_ready=1 -> issue order 0, 3, 7 on consecutive cycles; ptr ends at 0.
REQ-036 wb_ready=0 for 4 cycles with a request held -> payload unchanged; a second take to the same lane is stored as pending, no drop_pulse.
REQ-037 Two takes to lane 4 (values 9, then 11) while the output stage is stalled on lane 1 -> drop_pulse[4]=1 for one cycle; lane 4 later issues take=11.
REQ-038 flush while wb_valid=1 with pend=8'hF0 and a same-cycle take on lane 0 -> next cycle wb_valid=0, busy=0, no issue for lane 0.
REQ-039 rst asserted while wb_valid=1 and wb_ready=0 -> all outputs zero next cycle; a new take then issues with latency 2.

Source files
------------

// File: rtl/conveyor_drain_pkg.sv
// Shared sizing and lane-slicing helpers for the conveyor drain and the pool merger.
package conveyor_drain_pkg;

    localparam int unsigned NUM_REGS     = 8;
    localparam int unsigned STAMP_W      = 3;
    localparam int unsigned TAKE_W       = 5;
    localparam int unsigned IDX_W        = 3;

    localparam int unsigned STAMP_FLAT_W = NUM_REGS * STAMP_W;
    localparam int unsigned TAKE_FLAT_W  = NUM_REGS * TAKE_W;

    // Narrow select widths keep part-select bases exactly as wide as the vectors need.
    localparam int unsigned STAMP_SEL_W  = $clog2(STAMP_FLAT_W);
    localparam int unsigned TAKE_SEL_W   = $clog2(TAKE_FLAT_W);

    typedef logic [IDX_W-1:0]   reg_idx_t;
    typedef logic [STAMP_W-1:0] stamp_t;
    typedef logic [TAKE_W-1:0]  take_t;

    // Extract lane 'lane' from a flat stamp bus.
    function automatic stamp_t stamp_lane(input logic [STAMP_FLAT_W-1:0] flat,
                                          input reg_idx_t                lane);
        logic [STAMP_SEL_W-1:0] base;
        base = STAMP_SEL_W'(lane) * STAMP_SEL_W'(STAMP_W);
        return flat[base +: STAMP_W];
    endfunction

    // Extract lane 'lane' from a flat take bus.
    function automatic take_t take_lane(input logic [TAKE_FLAT_W-1:0] flat,
                                        input reg_idx_t               lane);
        logic [TAKE_SEL_W-1:0] base;
        base = TAKE_SEL_W'(lane) * TAKE_SEL_W'(TAKE_W);
        return flat[base +: TAKE_W];
    endfunction

    // Round-robin successor; the 3-bit index wraps 7 -> 0 on its own.
    function automatic reg_idx_t next_ptr(input reg_idx_t idx);
        return idx + reg_idx_t'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin picker: first requester at or after ptr, searching upward with wrap.
module rr_arbiter8
    import conveyor_drain_pkg::*;
(
    input  logic [NUM_REGS-1:0] req,
    input  reg_idx_t            ptr,
    output logic                gnt_valid,
    output reg_idx_t            gnt_idx
);

    reg_idx_t w_idx;

    // Scan from the farthest offset down so the nearest requester to ptr wins last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = ptr;
        w_idx     = '0;
        for (int k = NUM_REGS - 1; k >= 0; k--) begin
            w_idx = ptr + reg_idx_t'(k);
            if (req[w_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/conveyor_drain.sv
// Collects per-register stamps and takes, then drains pending takes one per cycle
// through a registered writeback stage with valid/ready handshake.
module conveyor_drain
    import conveyor_drain_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STAMP_FLAT_W-1:0] conveyor_stamp_flat,
    input  logic [NUM_REGS-1:0]     conveyor_stamp_in,
    input  logic [TAKE_FLAT_W-1:0]  conveyor_take_flat,
    input  logic [NUM_REGS-1:0]     conveyor_take_in,
    input  logic                    flush,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output reg_idx_t                wb_reg,
    output take_t                   wb_take,
    output stamp_t                  wb_stamp,
    output logic [NUM_REGS-1:0]     busy,
    output logic [NUM_REGS-1:0]     drop_pulse
);

    // Per-register holding state.
    stamp_t              r_stamp [NUM_REGS];
    take_t               r_take  [NUM_REGS];
    logic [NUM_REGS-1:0] r_pend;
    logic [NUM_REGS-1:0] r_drop;
    reg_idx_t            r_ptr;

    // Writeback stage.
    logic                r_wb_valid;
    reg_idx_t            r_wb_reg;
    take_t               r_wb_take;
    stamp_t              r_wb_stamp;

    logic                w_free;
    logic                w_gnt_valid;
    reg_idx_t            w_gnt_idx;
    logic                w_issue;
    logic [NUM_REGS-1:0] w_win;
    logic [NUM_REGS-1:0] w_take_acc;
    logic [NUM_REGS-1:0] w_pend_nxt;
    logic [NUM_REGS-1:0] w_drop_nxt;

    rr_arbiter8 u_arb (
        .req       (r_pend),
        .ptr       (r_ptr),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    // Issue decision, pending-set update and overwrite detection.
    always_comb begin
        w_free     = !r_wb_valid || wb_ready;
        w_issue    = w_free && w_gnt_valid && !flush;
        w_win      = '0;
        if (w_issue) begin
            w_win[w_gnt_idx] = 1'b1;
        end
        // Flush discards same-edge takes outright.
        w_take_acc = flush ? '0 : conveyor_take_in;
        // A take for the lane being issued re-arms it instead of counting as a drop.
        w_pend_nxt = flush ? '0 : ((r_pend & ~w_win) | w_take_acc);
        w_drop_nxt = w_take_acc & r_pend & ~w_win;
    end

    // Lane registers: stamps always latch (even on flush), takes only when accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_stamp[i] <= '0;
                r_take[i]  <= '0;
            end
            r_pend <= '0;
            r_drop <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (conveyor_stamp_in[i]) begin
                    r_stamp[i] <= stamp_lane(conveyor_stamp_flat, reg_idx_t'(i));
                end
                if (w_take_acc[i]) begin
                    r_take[i] <= take_lane(conveyor_take_flat, reg_idx_t'(i));
                end
            end
            r_pend <= w_pend_nxt;
            r_drop <= w_drop_nxt;
        end
    end

    // Writeback stage load/hold/drain and round-robin pointer advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid <= 1'b0;
            r_wb_reg   <= '0;
            r_wb_take  <= '0;
            r_wb_stamp <= '0;
            r_ptr      <= '0;
        end else if (flush) begin
            r_wb_valid <= 1'b0;
        end else if (w_free) begin
            r_wb_valid <= w_gnt_valid;
            if (w_gnt_valid) begin
                r_wb_reg   <= w_gnt_idx;
                r_wb_take  <= r_take[w_gnt_idx];
                r_wb_stamp <= r_stamp[w_gnt_idx];
                r_ptr      <= next_ptr(w_gnt_idx);
            end
        end
    end

    // Busy covers both pending lanes and the lane currently sitting in writeback.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            busy[i] = r_pend[i] | (r_wb_valid && (r_wb_reg == reg_idx_t'(i)));
        end
    end

    assign wb_valid   = r_wb_valid;
    assign wb_reg     = r_wb_reg;
    assign wb_take    = r_wb_take;
    assign wb_stamp   = r_wb_stamp;
    assign drop_pulse = r_drop;

endmodule

// File: tb/tb_conveyor_drain.sv
// Bench for conveyor_drain: directed scenarios with literal expectations plus a long
// randomized run, all checked every cycle against a queue-free behavioural model.
module tb_conveyor_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] sflat;
    logic [7:0]  sin;
    logic [39:0] tflat;
    logic [7:0]  tin;
    logic        flush;
    logic        wb_ready;
    logic        wb_valid;
    logic [2:0]  wb_reg;
    logic [4:0]  wb_take;
    logic [2:0]  wb_stamp;
    logic [7:0]  busy;
    logic [7:0]  drop_pulse;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state.
    bit [7:0] m_pend;
    bit [7:0] m_drop;
    int       m_tk [8];
    int       m_st [8];
    int       m_ptr;
    bit       m_v;
    int       m_reg;
    int       m_take;
    int       m_stamp;

    conveyor_drain dut (
        .clk                 (clk),
        .rst                 (rst),
        .conveyor_stamp_flat (sflat),
        .conveyor_stamp_in   (sin),
        .conveyor_take_flat  (tflat),
        .conveyor_take_in    (tin),
        .flush               (flush),
        .wb_valid            (wb_valid),
        .wb_ready            (wb_ready),
        .wb_reg              (wb_reg),
        .wb_take             (wb_take),
        .wb_stamp            (wb_stamp),
        .busy                (busy),
        .drop_pulse          (drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_busy();
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = m_pend[i] | (m_v && (m_reg == i));
        end
        return b;
    endfunction

    // One clock edge of the model, from the architectural rules.
    task automatic model_update();
        bit       free;
        int       win;
        bit [7:0] drop;
        int       j;
        if (rst) begin
            m_pend = '0; m_drop = '0; m_ptr = 0; m_v = 1'b0;
            m_reg = 0; m_take = 0; m_stamp = 0;
            for (int i = 0; i < 8; i++) begin
                m_tk[i] = 0;
                m_st[i] = 0;
            end
        end else begin
            free = !m_v || wb_ready;
            win  = -1;
            drop = '0;
            if (free && !flush) begin
                for (int k = 0; k < 8; k++) begin
                    j = (m_ptr + k) % 8;
                    if (win < 0 && m_pend[j]) win = j;
                end
            end
            if (flush) begin
                m_v = 1'b0;
            end else if (free) begin
                if (win >= 0) begin
                    m_v = 1'b1; m_reg = win; m_take = m_tk[win]; m_stamp = m_st[win];
                    m_pend[win] = 1'b0;
                    m_ptr = (win + 1) % 8;
                end else begin
                    m_v = 1'b0;
                end
            end
            for (int i = 0; i < 8; i++) begin
                if (sin[i]) m_st[i] = int'(sflat[3*i +: 3]);
            end
            if (!flush) begin
                for (int i = 0; i < 8; i++) begin
                    if (tin[i]) begin
                        if (m_pend[i]) drop[i] = 1'b1;
                        m_tk[i]   = int'(tflat[5*i +: 5]);
                        m_pend[i] = 1'b1;
                    end
                end
            end else begin
                m_pend = '0;
            end
            m_drop = drop;
        end
    endtask

    // Compare every cycle, mid-cycle, against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("wb_valid", 32'(wb_valid), 32'(m_v));
            chk("wb_reg", 32'(wb_reg), 32'(m_reg));
            chk("wb_take", 32'(wb_take), 32'(m_take));
            chk("wb_stamp", 32'(wb_stamp), 32'(m_stamp));
            chk("busy", 32'(busy), 32'(exp_busy()));
            chk("drop_pulse", 32'(drop_pulse), 32'(m_drop));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        sin = '0; tin = '0; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic set_take(input int lane, input int v);
        tin[lane] = 1'b1;
        tflat[5*lane +: 5] = 5'(v);
    endtask

    task automatic set_stamp(input int lane, input int v);
        sin[lane] = 1'b1;
        sflat[3*lane +: 3] = 3'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
    endtask

    initial begin
        rst = 1'b1; sflat = '0; sin = '0; tflat = '0; tin = '0; flush = 1'b0; wb_ready = 1'b1;
        step();
        chk_en = 1'b1;
        chk("reset_valid", 32'(wb_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);

        // Basic latency: take in cycle 0 shows in cycle 2, gone in cycle 3.
        wb_ready = 1'b1;
        set_stamp(2, 5); set_take(2, 17);
        step(); step();
        chk("lat_valid", 32'(wb_valid), 32'd1);
        chk("lat_reg", 32'(wb_reg), 32'd2);
        chk("lat_take", 32'(wb_take), 32'd17);
        chk("lat_stamp", 32'(wb_stamp), 32'd5);
        step();
        chk("lat_drain_valid", 32'(wb_valid), 32'd0);
        chk("lat_drain_busy", 32'(busy), 32'd0);

        // Round-robin order 0,3,7 then pointer back at 0 (lane 1 beats lane 7).
        do_reset();
        wb_ready = 1'b1;
        set_take(0, 1); set_take(3, 4); set_take(7, 8);
        step(); step();
        chk("rr_first", 32'(wb_reg), 32'd0);
        step();
        chk("rr_second", 32'(wb_reg), 32'd3);
        step();
        chk("rr_third", 32'(wb_reg), 32'd7);
        step();
        chk("rr_idle", 32'(wb_valid), 32'd0);
        set_take(7, 2); set_take(1, 3);
        step(); step();
        chk("rr_wrap", 32'(wb_reg), 32'd1);

        // Stall holds payload; re-take of the issued lane is pending without a drop.
        do_reset();
        wb_ready = 1'b0;
        set_take(5, 3); set_stamp(5, 6);
        step(); step();
        chk("stall_take", 32'(wb_take), 32'd3);
        set_take(5, 20);
        step();
        chk("stall_nodrop", 32'(drop_pulse), 32'd0);
        chk("stall_busy", 32'(busy), 32'h20);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stall_hold_take", 32'(wb_take), 32'd3);
            chk("stall_hold_stamp", 32'(wb_stamp), 32'd6);
        end
        wb_ready = 1'b1;
        step();
        chk("stall_next_take", 32'(wb_take), 32'd20);
        step();
        chk("stall_empty", 32'(wb_valid), 32'd0);

        // Overwrite of a pending take while stalled on lane 1.
        do_reset();
        wb_ready = 1'b0;
        set_take(1, 2);
        step(); step();
        chk("ovw_reg", 32'(wb_reg), 32'd1);
        set_take(4, 9);
        step();
        set_take(4, 11);
        step();
        chk("ovw_drop", 32'(drop_pulse), 32'h10);
        step();
        chk("ovw_drop_clear", 32'(drop_pulse), 32'd0);
        wb_ready = 1'b1;
        step();
        chk("ovw_reg4", 32'(wb_reg), 32'd4);
        chk("ovw_take11", 32'(wb_take), 32'd11);

        // Flush with pend=F0 in flight plus a same-edge take on lane 0.
        do_reset();
        wb_ready = 1'b0;
        set_take(2, 1); set_take(4, 1); set_take(5, 1); set_take(6, 1); set_take(7, 1);
        step(); step();
        chk("fl_busy_before", 32'(busy), 32'hF4);
        flush = 1'b1; set_take(0, 7);
        step();
        chk("fl_valid", 32'(wb_valid), 32'd0);
        chk("fl_busy", 32'(busy), 32'd0);
        wb_ready = 1'b1;
        step(); step();
        chk("fl_no_issue", 32'(wb_valid), 32'd0);

        // Reset mid-transfer, then a fresh take with latency 2.
        do_reset();
        wb_ready = 1'b0;
        set_take(3, 5); set_stamp(3, 7);
        step(); step();
        chk("rst_mid_valid", 32'(wb_valid), 32'd1);
        rst = 1'b1;
        step();
        chk("rst_out", {wb_valid, wb_reg, wb_take, wb_stamp, busy, drop_pulse}, 32'd0);
        set_take(6, 30);
        step();
        chk("rst_lat1", 32'(wb_valid), 32'd0);
        step();
        chk("rst_lat2_reg", 32'(wb_reg), 32'd6);
        chk("rst_lat2_take", 32'(wb_take), 32'd30);
        chk("rst_lat2_stamp", 32'(wb_stamp), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 199) == 0);
            flush    = ($urandom_range(0, 39) == 0);
            sflat    = 24'($urandom);
            sin      = 8'($urandom & $urandom);
            tflat    = 40'({$urandom, $urandom});
            tin      = 8'($urandom & $urandom & $urandom);
            wb_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
